muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for RV32M multiply/divide in the EX stage; runs beside the single-cycle ALU.
- Accepts one operation from EX and iterates a shift-add multiplier or a restoring divider, one bit per cycle.
- Holds the pipeline with a stall request while busy, then presents the result for one cycle so the instruction can advance.
- Aborts on pipeline flush, e.g. a taken branch.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- start  input  1  EX holds a valid M-extension instruction
- op  input  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  WIDTH  operand A (multiplicand/dividend)
- rs2  input  WIDTH  operand B (multiplier/divisor)
- flush  input  1  abort current operation
- stall_req  output  1  hold IF/ID/EX this cycle
- busy  output  1  registered; high in BUSY and DONE
- result_valid  output  1  one-cycle pulse; result is valid
- result  output  WIDTH  final result

Behaviour:
- Interface is fixed: one clock, clk; reset rstn is asynchronous and active-low.
- Reset values: state IDLE, busy 0, result_valid 0, result 0, counter 0, internal accumulators 0.
- States:
  - IDLE: start=1 and flush=0 at edge T latches the operands and op. Next state is DONE if a fast path applies, else BUSY.
  - BUSY: one iteration per cycle; counter counts 0..WIDTH-1. At count WIDTH-1 the next state is DONE.
  - DONE: result_valid=1 for exactly one cycle; next state IDLE.
- stall_req:
  - Combinational: (IDLE & start & !flush) | BUSY.
  - Low in DONE, so the instruction leaves EX in the same cycle as result_valid.
- Latency:
  - Normal: accept at edge T, result_valid high in cycle T+WIDTH+1 (33 cycles for WIDTH=32).
  - Fast path: result_valid high in cycle T+1.
- Sign handling:
  - Signed operands are converted to magnitudes at accept. The unsigned core produces a 2*WIDTH product, or a quotient plus remainder.
  - The sign is applied in the final iteration before DONE.
  - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
  - MUL returns product[WIDTH-1:0]; MULH* return product[2*WIDTH-1:WIDTH].
  - Quotient sign is sign(rs1) XOR sign(rs2). Remainder sign follows rs1.
- Fast paths (always present):
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- result: updates only on entry to DONE and holds until the next DONE. No X on result at any time.
- start while not IDLE is ignored; EX must keep the instruction stable, which stall_req guarantees.
- flush:
  - Any state returns to IDLE on the next edge; no result_valid; result keeps its old value.
  - flush with start in IDLE does not accept.
  - flush in DONE: the pulse still occurs in that cycle; EX discards it.
- Asynchronous reset mid-operation returns to IDLE immediately; the partial result is dropped.
- Counter wrap: no wrap; the counter is cleared on accept and on leaving BUSY.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined:
  - Multiply ops leave BUSY once the remaining shifted multiplier magnitude is zero.
  - Iterations = max(1, index of the MSB of |multiplier| + 1).
  - The sign fix is still applied before DONE.
  - Division is unchanged.
- When undefined, every non-fast-path op takes exactly WIDTH iterations.
- Results are identical either way; only latency differs.

Test Plan:
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> result 0xFFFFFFFE at cycle T+33; stall_req high T..T+32, low at T+33.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1); each 33 cycles.
- DIVU rs1=0x1234, rs2=0 -> 0xFFFFFFFF at T+1; REM rs1=0x80000000, rs2=0xFFFFFFFF -> 0 at T+1.
- MUL rs1=3, rs2=5, flush asserted at T+10 -> IDLE at T+11, no result_valid, result unchanged; a new start at T+12 is accepted.
- rstn pulsed low during BUSY -> busy, stall_req and result_valid drop immediately; after release, MUL 6x7 -> 42.
- With MULDIV_EARLY_OUT_EN: MUL rs1=9, rs2=3 -> 27 at T+3; without the macro -> 27 at T+33.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiplier and restoring divider, one bit per cycle.
// Optional `MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier magnitude is zero.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result
);

  // Handshake: start is sampled only in IDLE; EX holds the instruction while stall_req is high,
  // and result_valid pulses for exactly one cycle (DONE) with stall_req low so EX advances.
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2:0]         op_q;
  logic               a_neg_q, b_neg_q;
  logic               busy_q;
  logic [WIDTH-1:0]   result_q;

  logic               accept, a_neg, b_neg, div_zero, div_ovf, fast, last_iter;
  logic [WIDTH-1:0]   mag_a, mag_b, fast_result, iter_result;
  logic [2*WIDTH-1:0] acc_mul, acc_div, acc_step, prod_fix;
  logic [WIDTH:0]     shifted;
  logic               fits;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept = (state_q == IDLE) && start && !flush;

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
  assign a_neg  = ((op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110)) && rs1[WIDTH-1];
  assign b_neg  = ((op == 3'b001) || (op == 3'b100) || (op == 3'b110)) && rs2[WIDTH-1];
  assign mag_a  = a_neg ? (~rs1 + WIDTH'(1)) : rs1;
  assign mag_b  = b_neg ? (~rs2 + WIDTH'(1)) : rs2;

  assign div_zero    = op[2] && (rs2 == '0);
  assign div_ovf     = op[2] && !op[0] && (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&rs2);
  assign fast        = div_zero || div_ovf;
  assign fast_result = div_zero ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);

  // One iteration of either core; the divider keeps {remainder, quotient} in acc.
  assign acc_mul  = opb_q[0] ? (acc_q + mcand_q) : acc_q;
  assign shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign fits     = shifted >= {1'b0, opb_q};
  assign acc_div  = {fits ? (shifted[WIDTH-1:0] - opb_q) : shifted[WIDTH-1:0],
                     acc_q[WIDTH-2:0], fits};
  assign acc_step = op_q[2] ? acc_div : acc_mul;

`ifdef MULDIV_EARLY_OUT_EN
  assign last_iter = (cnt_q == CNT_W'(WIDTH-1)) || (!op_q[2] && (opb_q[WIDTH-1:1] == '0));
`else
  assign last_iter = (cnt_q == CNT_W'(WIDTH-1));
`endif

  // Sign fix applied to the final iteration's value before it is registered.
  assign prod_fix    = (a_neg_q ^ b_neg_q) ? (~acc_step + (2*WIDTH)'(1)) : acc_step;
  assign quo_fix     = (a_neg_q ^ b_neg_q) ? (~acc_step[WIDTH-1:0] + WIDTH'(1)) : acc_step[WIDTH-1:0];
  assign rem_fix     = a_neg_q ? (~acc_step[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_step[2*WIDTH-1:WIDTH];
  assign iter_result = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                               : ((op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d      = state_q;
    stall_req    = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        stall_req = start && !flush;
        if (accept) state_d = fast ? DONE : BUSY;
      end
      BUSY: begin
        stall_req = 1'b1;
        if (flush)          state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      op_q    <= op;
      a_neg_q <= a_neg;
      b_neg_q <= b_neg;
      acc_q   <= op[2] ? {{WIDTH{1'b0}}, mag_a} : '0;
      mcand_q <= {{WIDTH{1'b0}}, mag_a};
      opb_q   <= mag_b;
      if (fast) result_q <= fast_result;
    end else if (state_q == BUSY) begin
      if (flush) begin
        cnt_q <= '0;
      end else begin
        acc_q   <= acc_step;
        mcand_q <= mcand_q << 1;
        opb_q   <= op_q[2] ? opb_q : (opb_q >> 1);
        cnt_q   <= last_iter ? '0 : cnt_q + CNT_W'(1);
        if (last_iter) result_q <= iter_result;
      end
    end
  end

  assign busy   = busy_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: results, latency, stall_req, flush and async reset.
// Honors `MULDIV_EARLY_OUT_EN for expected multiply latency.
module tb_muldiv_seq;

  logic        clk, rstn, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        stall_req, busy, result_valid;
  logic [31:0] result;

  int n_vec, n_err;
  logic [31:0] last_exp;

  muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .rs1(rs1), .rs2(rs2), .flush(flush),
    .stall_req(stall_req), .busy(busy), .result_valid(result_valid), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

`ifdef MULDIV_EARLY_OUT_EN
  function automatic int mul_iters(input logic [2:0] o, input logic [31:0] b);
    logic [31:0] m;
    int n;
    m = (o == 3'b001 && b[31]) ? (~b + 32'd1) : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n;
  endfunction
`endif

  // Issue one op, then track cycles until result_valid; lat_in is the latency without early-out.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int lat_in);
    int lat, cyc;
    logic seen, stall_ok;
    lat = lat_in;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[2]) lat = mul_iters(o, b) + 1;
`endif
    @(posedge clk); #1;
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(negedge clk);
    check({tag, "_stall_accept"}, {31'd0, stall_req}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; rs1 = 32'hdead_beef; rs2 = 32'h0bad_f00d;
    cyc = 0; seen = 1'b0; stall_ok = 1'b1;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (result_valid) begin
        seen = 1'b1;
        if (stall_req !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
      end else if (stall_req !== 1'b1 || busy !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
    check({tag, "_result"}, result, exp_r);
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, busy, result_valid}, 32'd0);
    last_exp = exp_r;
  endtask

  initial begin
    logic saw_valid;
    logic [31:0] long_b;
    n_vec = 0; n_err = 0; last_exp = 32'd0;
    rstn = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {29'd0, busy, result_valid, stall_req}, 32'd0);
    check("reset_result", result, 32'd0);
    rstn = 1'b1;

    run_op("mulhu_ones",   3'b011, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 33);
    run_op("div_neg7_2",   3'b100, 32'hffff_fff9, 32'd2,         32'hffff_fffd, 33);
    run_op("rem_neg7_2",   3'b110, 32'hffff_fff9, 32'd2,         32'hffff_ffff, 33);
    run_op("divu_by0",     3'b101, 32'h0000_1234, 32'd0,         32'hffff_ffff, 1);
    run_op("rem_ovf",      3'b110, 32'h8000_0000, 32'hffff_ffff, 32'd0,         1);
    run_op("div_ovf",      3'b100, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1);
    run_op("remu_by0",     3'b111, 32'h0000_1234, 32'd0,         32'h0000_1234, 1);
    run_op("mul_9x3",      3'b000, 32'd9,         32'd3,         32'd27,        33);
    run_op("mulh_neg2x3",  3'b001, 32'hffff_fffe, 32'd3,         32'hffff_ffff, 33);
    run_op("mulhsu",       3'b010, 32'hffff_fffe, 32'hffff_ffff, 32'hffff_fffe, 33);
    run_op("mulh_min",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("divu_100_7",   3'b101, 32'd100,       32'd7,         32'd14,        33);
    run_op("remu_100_7",   3'b111, 32'd100,       32'd7,         32'd2,         33);
    run_op("div_7_neg2",   3'b100, 32'd7,         32'hffff_fffe, 32'hffff_fffd, 33);
    run_op("rem_7_neg2",   3'b110, 32'd7,         32'hffff_fffe, 32'd1,         33);
    run_op("mul_by0",      3'b000, 32'h1234_5678, 32'd0,         32'd0,         33);

    // Flush during BUSY; the multiplier is long enough to still be busy at T+10 in both builds.
`ifdef MULDIV_EARLY_OUT_EN
    long_b = 32'h5000_0000;
`else
    long_b = 32'd5;
`endif
    @(posedge clk); #1;
    start = 1'b1; op = 3'b000; rs1 = 32'd3; rs2 = long_b;
    @(posedge clk); #1;
    start = 1'b0;
    saw_valid = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (result_valid) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    if (result_valid) saw_valid = 1'b1;
    check("flush_stall_in_busy", {31'd0, stall_req}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    if (result_valid) saw_valid = 1'b1;
    check("flush_idle", {31'd0, busy}, 32'd0);
    check("flush_no_valid", {31'd0, saw_valid}, 32'd0);
    check("flush_result_held", result, last_exp);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd5, 32'd15, 33);

    // Flush with start in IDLE must not accept.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 3'b000; rs1 = 32'd2; rs2 = 32'd2;
    @(negedge clk);
    check("flush_start_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_no_accept", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a long multiply.
    @(posedge clk); #1;
    start = 1'b1; op = 3'b000; rs1 = 32'd1; rs2 = 32'hffff_ffff;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    check("async_reset_outputs", {29'd0, busy, stall_req, result_valid}, 32'd0);
    check("async_reset_result", result, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_op("mul_6x7", 3'b000, 32'd6, 32'd7, 32'd42, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
